uparc_mdu: RTL and testbench

Parametrised iterative multiply/divide unit, the sequential companion to the combinational ALU. It sits beside the ALU in the execute stage and implements MULT/MULTU/DIV/DIVU into an architectural HI/LO register pair, plus MTHI/MTLO. A start/busy/done handshake lets the pipeline control stall on HI/LO readers. Operand width is a parameter; signed operations use magnitude arithmetic with a final sign-correction cycle.

---
 rtl/uparc_mdu_pkg.sv | 15 +
 rtl/uparc_mdu.sv | 160 ++++++++++++++++
 tb/tb_uparc_mdu.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uparc_mdu_pkg.sv
// Shared constants for the uparc multiply/divide unit: register width and MDU opcodes.
package uparc_mdu_pkg;

    localparam int UPARC_REG_WIDTH   = 32;
    localparam int UPARC_MDUOP_WIDTH = 3;

    localparam logic [UPARC_MDUOP_WIDTH-1:0] UPARC_MDUOP_NONE  = 3'd0;
    localparam logic [UPARC_MDUOP_WIDTH-1:0] UPARC_MDUOP_MULT  = 3'd1;
    localparam logic [UPARC_MDUOP_WIDTH-1:0] UPARC_MDUOP_MULTU = 3'd2;
    localparam logic [UPARC_MDUOP_WIDTH-1:0] UPARC_MDUOP_DIV   = 3'd3;
    localparam logic [UPARC_MDUOP_WIDTH-1:0] UPARC_MDUOP_DIVU  = 3'd4;
    localparam logic [UPARC_MDUOP_WIDTH-1:0] UPARC_MDUOP_MTHI  = 3'd5;
    localparam logic [UPARC_MDUOP_WIDTH-1:0] UPARC_MDUOP_MTLO  = 3'd6;

endpackage

// File: rtl/uparc_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; a final FIX cycle restores the result signs.
module uparc_mdu
    import uparc_mdu_pkg::*;
#(
    parameter int WIDTH = UPARC_REG_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [UPARC_MDUOP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         cancel,
    output logic [WIDTH-1:0]             hi,
    output logic [WIDTH-1:0]             lo,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]         state_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic               is_div_r;

    logic               accept_s;
    logic               is_mul_s;
    logic               is_dv_s;
    logic               sgn_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_rem_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        cond_neg = n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Opcode decode and operand magnitudes for the accepting cycle.
    always_comb begin
        is_mul_s = 1'b0;
        is_dv_s  = 1'b0;
        sgn_s    = 1'b0;
        case (op)
            UPARC_MDUOP_MULT:  begin is_mul_s = 1'b1; sgn_s = 1'b1; end
            UPARC_MDUOP_MULTU: begin is_mul_s = 1'b1; end
            UPARC_MDUOP_DIV:   begin is_dv_s  = 1'b1; sgn_s = 1'b1; end
            UPARC_MDUOP_DIVU:  begin is_dv_s  = 1'b1; end
            default:           begin is_mul_s = 1'b0; end
        endcase
        accept_s = (state_r == ST_IDLE) && start && !cancel;
        abs_a_s  = cond_neg(a, sgn_s & a[WIDTH-1]);
        abs_b_s  = cond_neg(b, sgn_s & b[WIDTH-1]);
    end

    // One shift-add or restoring-divide iteration on the accumulator.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r & {WIDTH{acc_r[0]}}};
        div_rem_s  = acc_r[2*WIDTH-1:WIDTH-1];
        div_diff_s = div_rem_s[WIDTH-1:0] - opb_r;
        if (!is_div_r) begin
            step_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else if (div_rem_s >= {1'b0, opb_r}) begin
            step_acc_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            step_acc_s = {div_rem_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction: separate quotient/remainder negation, or a full 2W product negation.
    always_comb begin
        fix_lo_s = cond_neg(acc_r[WIDTH-1:0], neg_lo_r);
        if (is_div_r) begin
            fix_hi_s = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_hi_r);
        end else if (neg_lo_r) begin
            fix_hi_s = ~acc_r[2*WIDTH-1:WIDTH]
                     + {{(WIDTH-1){1'b0}}, (acc_r[WIDTH-1:0] == {WIDTH{1'b0}})};
        end else begin
            fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            acc_r    <= {(2*WIDTH){1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            is_div_r <= 1'b0;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (is_mul_s || is_dv_s)) begin
                        state_r  <= ST_RUN;
                        busy     <= 1'b1;
                        acc_r    <= {{WIDTH{1'b0}}, abs_a_s};
                        opb_r    <= abs_b_s;
                        cnt_r    <= CNT_W'(WIDTH);
                        is_div_r <= is_dv_s;
                        neg_hi_r <= sgn_s & is_dv_s & a[WIDTH-1];
                        // Divide by zero keeps the all-ones quotient unsigned-looking.
                        neg_lo_r <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1])
                                  & (is_mul_s | (b != {WIDTH{1'b0}}));
                    end else if (accept_s && (op == UPARC_MDUOP_MTHI)) begin
                        hi <= a;
                    end else if (accept_s && (op == UPARC_MDUOP_MTLO)) begin
                        lo <= a;
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        acc_r <= step_acc_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            state_r <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    if (!cancel) begin
                        hi   <= fix_hi_s;
                        lo   <= fix_lo_s;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uparc_mdu.sv
// Self-checking bench for uparc_mdu at WIDTH=32: directed corner cases plus
// randomized MULT/DIV traffic against an arithmetic reference model.
module tb_uparc_mdu;
    import uparc_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    uparc_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model from plain 64-bit arithmetic.
    function automatic void model(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        eh = 32'd0;
        el = 32'd0;
        case (mop)
            UPARC_MDUOP_MULT:  begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
            UPARC_MDUOP_MULTU: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
            UPARC_MDUOP_DIV: begin
                if (y == 32'd0) begin el = 32'hFFFF_FFFF; eh = x; end
                else begin q = sx / sy; r = sx % sy; p = 64'(q); el = p[31:0]; p = 64'(r); eh = p[31:0]; end
            end
            UPARC_MDUOP_DIVU: begin
                if (y == 32'd0) begin el = 32'hFFFF_FFFF; eh = x; end
                else begin el = x / y; eh = x % y; end
            end
            default: begin eh = 32'd0; el = 32'd0; end
        endcase
    endfunction

    // Drive one start cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = mop; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = UPARC_MDUOP_NONE; a = $urandom; b = $urandom;
    endtask

    // Issue an op and wait (bounded) for done; reports latency and handshake observations.
    task automatic run_op(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] h, output logic [31:0] l, output int lat,
                          output int busy_gaps, output logic busy_at_done, output logic done_after);
        issue(mop, x, y);
        lat = 1;
        busy_gaps = 0;
        while (!done && lat < 200) begin
            if (!busy) busy_gaps++;
            @(negedge clk);
            lat++;
        end
        h = hi; l = lo; busy_at_done = busy;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({hi, lo, busy, done} !== 66'd0) begin n_err++; $display("FAIL reset_in: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({hi, lo, busy, done} !== 66'd0) begin n_err++; $display("FAIL reset_out: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [8] = '{UPARC_MDUOP_MULT, UPARC_MDUOP_MULTU, UPARC_MDUOP_DIV, UPARC_MDUOP_DIVU,
                                 UPARC_MDUOP_DIVU, UPARC_MDUOP_DIV, UPARC_MDUOP_DIV, UPARC_MDUOP_MULT};
        logic [31:0] av [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100,
                                32'd100, 32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] bv [8] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        logic [31:0] wh [8] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'd100, 32'd0, 32'hFFFF_FFF9, 32'h4000_0000};
        logic [31:0] wl [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] h, l;
        int          lat, gaps;
        logic        bd, da;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], av[i], bv[i], h, l, lat, gaps, bd, da);
            n_cmp++; if (h !== wh[i] || l !== wl[i]) begin n_err++; $display("FAIL directed_%0d: hi=%h lo=%h want hi=%h lo=%h", i, h, l, wh[i], wl[i]); end
            n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL latency_%0d: done at cycle %0d want 34", i, lat); end
            n_cmp++; if (gaps !== 0 || bd !== 1'b0 || da !== 1'b0) begin n_err++; $display("FAIL handshake_%0d: busy gaps=%0d busy@done=%b done next=%b want 0/0/0", i, gaps, bd, da); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  mop;
        logic [31:0] x, y, h, l, eh, el;
        int          lat, gaps;
        logic        bd, da;
        for (int i = 0; i < 24; i++) begin
            mop = 3'($urandom_range(1, 4));
            x = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) x = 32'h8000_0000;
            model(mop, x, y, eh, el);
            run_op(mop, x, y, h, l, lat, gaps, bd, da);
            n_cmp++; if (h !== eh || l !== el || lat !== 34) begin n_err++; $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=34", i, mop, x, y, h, l, lat, eh, el); end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo_prev, eh, el;
        issue(UPARC_MDUOP_MTHI, 32'h1234_5678, 32'd0);
        n_cmp++; if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mthi: hi=%h busy=%b done=%b want 12345678/0/0", hi, busy, done); end
        issue(UPARC_MDUOP_MTLO, 32'hCAFE_F00D, 32'd0);
        n_cmp++; if (lo !== 32'hCAFE_F00D || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mtlo: lo=%h busy=%b done=%b want cafef00d/0/0", lo, busy, done); end
        issue(UPARC_MDUOP_NONE, 32'hDEAD_BEEF, 32'd1);
        n_cmp++; if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D || busy !== 1'b0) begin n_err++; $display("FAIL op_none: hi=%h lo=%h busy=%b want 12345678/cafef00d/0", hi, lo, busy); end
        // MTLO attempted mid-MULT must be dropped.
        lo_prev = lo;
        model(UPARC_MDUOP_MULTU, 32'd1000, 32'd3000, eh, el);
        issue(UPARC_MDUOP_MULTU, 32'd1000, 32'd3000);
        repeat (4) @(negedge clk);
        start = 1'b1; op = UPARC_MDUOP_MTLO; a = 32'h5555_AAAA;
        @(negedge clk);
        start = 1'b0; op = UPARC_MDUOP_NONE;
        n_cmp++; if (lo !== lo_prev || busy !== 1'b1) begin n_err++; $display("FAIL mtlo_busy: lo=%h busy=%b want %h/1", lo, busy, lo_prev); end
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || hi !== eh || lo !== el) begin n_err++; $display("FAIL mtlo_busy_result: done=%b hi=%h lo=%h want 1/%h/%h", done, hi, lo, eh, el); end
    endtask

    task automatic test_cancel();
        int          at [2] = '{10, 33};
        int          seen;
        logic [31:0] hp, lp;
        issue(UPARC_MDUOP_MTHI, 32'hA5A5_0001, 32'd0);
        issue(UPARC_MDUOP_MTLO, 32'h5A5A_0002, 32'd0);
        for (int k = 0; k < 2; k++) begin
            hp = hi; lp = lo;
            issue(UPARC_MDUOP_MULT, 32'hFFFF_FFFF, 32'd2);
            repeat (at[k] - 1) @(negedge clk);
            cancel = 1'b1;
            @(negedge clk);
            cancel = 1'b0;
            n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL cancel_c%0d: busy=%b done=%b want 0/0", at[k], busy, done); end
            seen = 0;
            repeat (40) begin @(negedge clk); if (done) seen++; end
            n_cmp++; if (seen !== 0 || hi !== hp || lo !== lp) begin n_err++; $display("FAIL cancel_keep_c%0d: done pulses=%0d hi=%h lo=%h want 0/%h/%h", at[k], seen, hi, lo, hp, lp); end
        end
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = UPARC_MDUOP_MTHI; a = 32'h0BAD_0BAD;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = UPARC_MDUOP_NONE;
        n_cmp++; if (hi !== hp || busy !== 1'b0) begin n_err++; $display("FAIL cancel_wins: hi=%h busy=%b want %h/0", hi, busy, hp); end
    endtask

    task automatic test_async_reset();
        logic [31:0] h, l;
        int          lat, gaps;
        logic        bd, da;
        issue(UPARC_MDUOP_DIV, 32'hFFFF_FF00, 32'd3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({hi, lo, busy, done} !== 66'd0) begin n_err++; $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done); end
        @(negedge clk);
        rst = 1'b0;
        run_op(UPARC_MDUOP_DIVU, 32'd9, 32'd3, h, l, lat, gaps, bd, da);
        n_cmp++; if (h !== 32'd0 || l !== 32'd3 || lat !== 34) begin n_err++; $display("FAIL divu_after_reset: hi=%h lo=%h lat=%0d want 0/3/34", h, l, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh1, el1, eh2, el2;
        int          lat;
        model(UPARC_MDUOP_MULT, 32'hFFFF_FFF0, 32'd12345, eh1, el1);
        model(UPARC_MDUOP_DIV, 32'h8000_0001, 32'hFFFF_FFF3, eh2, el2);
        issue(UPARC_MDUOP_MULT, 32'hFFFF_FFF0, 32'd12345);
        lat = 1;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
        n_cmp++; if (hi !== eh1 || lo !== el1 || lat !== 34) begin n_err++; $display("FAIL b2b_first: hi=%h lo=%h lat=%0d want %h/%h/34", hi, lo, lat, eh1, el1); end
        start = 1'b1; op = UPARC_MDUOP_DIV; a = 32'h8000_0001; b = 32'hFFFF_FFF3;
        @(negedge clk);
        start = 1'b0; op = UPARC_MDUOP_NONE;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_accept: busy=%b done=%b want 1/0", busy, done); end
        lat = 1;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
        n_cmp++; if (hi !== eh2 || lo !== el2 || lat !== 34) begin n_err++; $display("FAIL b2b_second: hi=%h lo=%h lat=%0d want %h/%h/34", hi, lo, lat, eh2, el2); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_cancel();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
